// File: rtl/serial_in_register.sv
// serial_in_register
//   Assembles a W-bit word from a serial stream (LSB first) and presents it
//   on a registered parallel output with a simple valid/ready hold.
//
//   Handshake: dout_valid=1 means dout (and par_err) hold a complete word
//   that the downstream register has not yet taken. The word transfers on a
//   rising clk edge where dout_valid=1 and out_ready=1; dout_valid drops in
//   the following cycle. out_ready has no effect while dout_valid=0.
//
//   Optional feature (macro PARITY_CHECK_EN): one extra sin_en-qualified bit
//   is sampled after the data as an even-parity bit, and par_err reports
//   the XOR of all data bits and that parity bit. Without the macro the
//   parity state and logic are absent and par_err is tied to 0.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous reset, active low
//   start      in   frame start request (honoured in IDLE, or in HOLD
//                   together with out_ready for back-to-back frames)
//   sin        in   serial data, LSB first
//   sin_en     in   sin is sampled only when 1
//   out_ready  in   downstream accepts the held word
//   dout       out  assembled word (W bits), registered
//   dout_valid out  dout holds a complete, unaccepted word
//   busy       out  a frame is being shifted in
//   par_err    out  parity error, qualified by dout_valid
//   state_dbg  out  current FSM state encoding, for observation only
module serial_in_register #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sin,
  input  logic         sin_en,
  input  logic         out_ready,
  output logic [W-1:0] dout,
  output logic         dout_valid,
  output logic         busy,
  output logic         par_err,
  output logic [1:0]   state_dbg
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

`ifdef PARITY_CHECK_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    HOLD   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    HOLD   = 2'd3
  } state_t;
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  sreg_q, sreg_d;
  logic [W-1:0]  dout_q, dout_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic [W-1:0]  shifted;

`ifdef PARITY_CHECK_EN
  logic          perr_q, perr_d;
`endif

  // New bit enters at the top so the first sampled bit ends up in bit 0.
  assign shifted = {sin, sreg_q[W-1:1]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    dout_d  = dout_q;
    valid_d = valid_q;
    busy_d  = busy_q;
`ifdef PARITY_CHECK_EN
    perr_d  = perr_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      SHIFT: begin
        if (sin_en) begin
          sreg_d = shifted;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            cnt_d = '0;
`ifdef PARITY_CHECK_EN
            state_d = PARITY;
`else
            // Load the output on the same edge that samples the last bit,
            // so the word is visible in the very next cycle.
            state_d = HOLD;
            dout_d  = shifted;
            valid_d = 1'b1;
            busy_d  = 1'b0;
`endif
          end
        end
      end
`ifdef PARITY_CHECK_EN
      PARITY: begin
        if (sin_en) begin
          state_d = HOLD;
          dout_d  = sreg_q;
          perr_d  = ^{sreg_q, sin};
          valid_d = 1'b1;
          busy_d  = 1'b0;
        end
      end
`endif
      HOLD: begin
        // The held word is only released by out_ready; start alone never
        // overwrites it.
        if (out_ready) begin
          valid_d = 1'b0;
          if (start) begin
            state_d = SHIFT;
            cnt_d   = '0;
            busy_d  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sreg_q  <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

`ifdef PARITY_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end

  assign par_err = perr_q;
`else
  assign par_err = 1'b0;
`endif

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign busy       = busy_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_serial_in_register.sv
// tb_serial_in_register
//   Table-driven frames plus hand-written corner sequences and randomized
//   frames for serial_in_register (W=8). Expected words come from a
//   scoreboard queue fed by the stimulus; parity expectations come from a
//   population count of the frame bits.
module tb_serial_in_register;

  localparam int W = 8;
`ifdef PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sin;
  logic         sin_en;
  logic         out_ready;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic         busy;
  logic         par_err;
  logic [1:0]   state_dbg;

  always #5 clk = ~clk;

  serial_in_register #(.W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .sin        (sin),
    .sin_en     (sin_en),
    .out_ready  (out_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .par_err    (par_err),
    .state_dbg  (state_dbg)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int           n_vec = 0;
  int           n_err = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Parity reference: odd number of ones across data + parity bit.
  function automatic logic ref_par(input logic [W-1:0] w, input logic pbit);
    int ones;
    ones = $countones(w) + int'(pbit);
    return PAR_EN ? logic'(ones % 2) : 1'b0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one frame: optional start pulse, W data bits (+ parity bit when
  // enabled) with random gaps of 0..gap_max idle cycles before each sample.
  task automatic run_frame(input logic [W-1:0] word, input int gap_max,
                           input logic pbit, input bit do_start);
    logic [W:0] bits;
    int         nsamp;
    int         g;
    bits  = {pbit, word};
    nsamp = W + (PAR_EN ? 1 : 0);
    if (do_start) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_busy", busy, 1);
    end
    exp_q.push_back(word);
    for (int i = 0; i < nsamp; i++) begin
      g = $urandom_range(gap_max, 0);
      for (int k = 0; k < g; k++) begin
        sin_en = 1'b0;
        sin    = 1'($urandom);
        start  = 1'($urandom);
        tick();
        check("gap_valid", dout_valid, 0);
        check("gap_busy", busy, 1);
      end
      sin    = bits[i];
      sin_en = 1'b1;
      tick();
      sin_en = 1'b0;
      start  = 1'b0;
      if (i < nsamp - 1) check("early_valid", dout_valid, 0);
    end
    check("frame_valid", dout_valid, 1);
    check("frame_busy", busy, 0);
    check("frame_dout", dout, exp_q.pop_front());
    check("frame_par", par_err, ref_par(word, pbit));
  endtask

  // Stall in HOLD for n cycles (start pulsed), then accept the word.
  task automatic hold_release(input int n, input logic [W-1:0] word, input logic exp_par);
    for (int k = 0; k < n; k++) begin
      out_ready = 1'b0;
      start     = (k % 2 == 0);
      sin_en    = 1'($urandom);
      sin       = 1'($urandom);
      tick();
      check("hold_valid", dout_valid, 1);
      check("hold_dout", dout, word);
      check("hold_busy", busy, 0);
      check("hold_par", par_err, exp_par);
    end
    start     = 1'b0;
    sin_en    = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("xfer_valid", dout_valid, 0);
    check("xfer_dout", dout, word);
    check("xfer_busy", busy, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [W-1:0] word;
    int           gap_max;
    int           hold;
    logic         pbit;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [W-1:0] w;
    logic         pb;

    vecs[0] = '{8'hA5, 0, 0, 1'b0};
    vecs[1] = '{8'hA5, 3, 5, 1'b1};
    vecs[2] = '{8'h3C, 0, 2, 1'b0};
    vecs[3] = '{8'hFF, 2, 1, 1'b1};
    vecs[4] = '{8'h00, 1, 0, 1'b0};

    rst = 1'b1; start = 1'b0; sin = 1'b0; sin_en = 1'b0; out_ready = 1'b0;
    #1 rst = 1'b0;
    #1;
    check("rst_dout", dout, 0);
    check("rst_valid", dout_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_par", par_err, 0);
    #10 rst = 1'b1;
    tick();

    // IDLE ignores sin/sin_en/out_ready.
    for (int k = 0; k < 3; k++) begin
      sin_en = 1'b1; sin = 1'($urandom); out_ready = 1'($urandom);
      tick();
      check("idle_busy", busy, 0);
      check("idle_valid", dout_valid, 0);
    end
    sin_en = 1'b0; out_ready = 1'b0;

    // Table-driven frames (includes 0xA5 with gaps and a 5-cycle stall).
    for (int v = 0; v < 5; v++) begin
      run_frame(vecs[v].word, vecs[v].gap_max, vecs[v].pbit, 1'b1);
      hold_release(vecs[v].hold, vecs[v].word, ref_par(vecs[v].word, vecs[v].pbit));
    end

    // Back-to-back: accept + start together in HOLD, then frame 0x3C.
    run_frame(8'hA5, 0, 1'b0, 1'b1);
    out_ready = 1'b1; start = 1'b1;
    tick();
    out_ready = 1'b0; start = 1'b0;
    check("b2b_busy", busy, 1);
    check("b2b_valid", dout_valid, 0);
    check("b2b_dout", dout, 8'hA5);
    run_frame(8'h3C, 1, 1'b0, 1'b0);
    hold_release(1, 8'h3C, ref_par(8'h3C, 1'b0));

    // Reset after 3 sampled bits; asynchronous clear, then frame 0xFF.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sin = 1'b1; sin_en = 1'b1;
      tick();
    end
    sin_en = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("arst_dout", dout, 0);
    check("arst_valid", dout_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_par", par_err, 0);
    @(posedge clk);
    #3 rst = 1'b1;
    sin_en = 1'b1; sin = 1'b1;
    tick();
    tick();
    sin_en = 1'b0;
    check("post_rst_busy", busy, 0);
    check("post_rst_valid", dout_valid, 0);
    run_frame(8'hFF, 0, 1'b0, 1'b1);
    hold_release(0, 8'hFF, ref_par(8'hFF, 1'b0));

    // Randomized frames.
    for (int r = 0; r < 20; r++) begin
      w  = W'($urandom);
      pb = 1'($urandom);
      run_frame(w, 3, pb, 1'b1);
      hold_release($urandom_range(3, 0), w, ref_par(w, pb));
    end

    check("sb_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_in_register.md
SERIAL_IN_REGISTER -- requirements
Module: serial_in_register

Interface
REQ-001 The block SHALL have parameter W, default 8, data word width in bits, legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low (0 = reset).
REQ-004 The block SHALL have port start, input, 1 bit: frame start request.
REQ-005 The block SHALL have port sin, input, 1 bit: serial data, LSB first.
REQ-006 The block SHALL have port sin_en, input, 1 bit: sin is sampled only in cycles where sin_en=1.
REQ-007 The block SHALL have port out_ready, input, 1 bit: the downstream parallel register accepts the word.
REQ-008 The block SHALL have port dout, output, W bits: assembled word, registered.
REQ-009 The block SHALL have port dout_valid, output, 1 bit: dout holds a complete, unaccepted word.
REQ-010 The block SHALL have port busy, output, 1 bit: a frame is being shifted in.
REQ-011 The block SHALL have port par_err, output, 1 bit: parity error flag, qualified by dout_valid.

Function
REQ-012 The FSM SHALL have exactly the states IDLE, SHIFT, PARITY (present only with the macro) and HOLD; all outputs SHALL be registered.
REQ-013 IDLE: start=1 -> SHIFT with bit counter cleared to 0; sin and sin_en are ignored in IDLE.
REQ-014 SHIFT: each cycle with sin_en=1, the shift register SHALL shift right, sin SHALL enter bit W-1, and the counter SHALL increment; sin_en=0 cycles SHALL hold all state (gaps of any length are legal).
REQ-015 On the W-th sampled bit, the FSM SHALL go to HOLD (or to PARITY with the macro); dout SHALL be loaded and dout_valid SHALL be 1 in the very next cycle, i.e. 1-cycle latency from the last data-bit sample edge.
REQ-016 After a frame, dout[0] SHALL equal the first sampled bit and dout[W-1] the last.
REQ-017 busy SHALL be 1 in SHIFT and PARITY, and 0 in IDLE and HOLD.
REQ-018 start SHALL be ignored in SHIFT and PARITY; it SHALL NOT restart the frame.
REQ-019 HOLD: dout, dout_valid and par_err SHALL stay stable until a cycle with out_ready=1, at which the transfer occurs and dout_valid SHALL be 0 in the next cycle.
REQ-020 HOLD with out_ready=1 and start=1 in the same cycle SHALL go directly to SHIFT with the counter cleared (back-to-back frames, no IDLE cycle).
REQ-021 HOLD with out_ready=0 and start=1 SHALL ignore start; no overrun SHALL occur and the held word SHALL never be overwritten.
REQ-022 dout SHALL retain the last word after transfer and change only when the next frame completes.
REQ-023 out_ready SHALL be don't-care outside HOLD.

Reset
REQ-024 rst=0 SHALL immediately (without waiting for clk) force IDLE, counter=0, shift register=0, dout=0, dout_valid=0, busy=0, par_err=0.
REQ-025 Assertion of rst mid-frame or in HOLD SHALL discard the partial or held word.
REQ-026 After rst returns to 1, the block SHALL wait for a new start.

Configuration
REQ-027 With macro PARITY_CHECK_EN defined, after the W data bits the FSM SHALL enter PARITY and sample one further sin_en-qualified bit as an even-parity bit, then enter HOLD; par_err SHALL equal the XOR of the W data bits and the parity bit, and SHALL be loaded together with dout.
REQ-028 Without PARITY_CHECK_EN, the PARITY state and parity logic SHALL be absent, par_err SHALL be constant 0, and the frame SHALL be exactly W sampled bits.

Verification
REQ-029 The bench SHALL cover: W=8, start, then bits 1,0,1,0,0,1,0,1 on consecutive sin_en cycles -> dout=0xA5 and dout_valid=1 one cycle after the 8th sample, busy=0.
REQ-030 The bench SHALL cover: same frame with sin_en gaps of 0..3 random cycles -> dout=0xA5, and dout_valid never rises before the 8th sample.
REQ-031 The bench SHALL cover: out_ready=0 for 5 cycles in HOLD with start pulsed -> dout stays 0xA5, start ignored; out_ready=1 -> dout_valid=0 the next cycle.
REQ-032 The bench SHALL cover: out_ready=1 and start=1 together in HOLD, then frame 0x3C -> busy=1 the next cycle and dout=0x3C after 8 samples.
REQ-033 The bench SHALL cover: rst=0 after 3 sampled bits -> all outputs 0 asynchronously; after release, the next frame 0xFF yields dout=0xFF.
REQ-034 The bench SHALL cover, with PARITY_CHECK_EN: frame 0xA5 with parity bit 0 -> par_err=0; with parity bit 1 -> par_err=1.
